// File: rtl/tx_fcs_insert.sv
// ---------------------------------------------------------------------------
// tx_fcs_insert
//
// Appends the Ethernet FCS (CRC-32) to each frame flowing from the MAC to the
// PHY-side transmitter. Payload bytes pass through with zero latency. The four
// FCS bytes follow the last payload byte. Optionally, short frames are
// zero-padded up to MIN_LEN bytes before the FCS.
//
// Build option:
//   TX_FCS_INSERT_PAD_EN  defined   -> padding to MIN_LEN is compiled in.
//                         undefined -> no PAD state, no counter, no MIN_LEN
//                                      parameter; frames go DATA -> FCS.
//
// Ports (tx_fcs_insert):
//   clk        in   clock, all state changes on the rising edge
//   reset_n    in   asynchronous active-low reset
//   in_data    in   [7:0] frame byte from the MAC, without FCS
//   in_valid   in   in_data valid
//   in_last    in   last payload byte of the frame (qualified by in_valid)
//   in_ready   out  block accepts in_data this cycle
//   out_data   out  [7:0] byte towards the transmitter
//   out_valid  out  out_data valid
//   out_last   out  last FCS byte (qualified by out_valid)
//   out_ready  in   downstream accepts out_data this cycle
//   busy       out  frame in progress (first accept .. last FCS accept)
//
// Ports (tx_fcs_crc32, the CRC engine):
//   clk, reset (async, active high), data [7:0], calc, clear,
//   crc_out [31:0] in transmit order (crc_out[31:24] is sent first)
// ---------------------------------------------------------------------------

module tx_fcs_crc32 (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        calc,
  input  logic        clear,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] crc_inv_s;

  // Reflected CRC-32 (poly 0x04C11DB7, LSB-first) over one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  d);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, d};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ 32'hEDB8_8320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // Next CRC value: clear wins over calc.
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = 32'hFFFF_FFFF;
    end else if (calc) begin
      crc_d = crc32_byte(crc_q, data);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= 32'hFFFF_FFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  // The wire carries the complemented remainder, least significant byte first.
  // Byte-swapping makes crc_out[31:24] the first byte on the wire.
  assign crc_inv_s = ~crc_q;
  assign crc_out   = {crc_inv_s[7:0], crc_inv_s[15:8], crc_inv_s[23:16], crc_inv_s[31:24]};

endmodule

module tx_fcs_insert
`ifdef TX_FCS_INSERT_PAD_EN
#(
  parameter int unsigned MIN_LEN = 60
)
`endif
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_PAD  = 2'd1,
    ST_FCS  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  idx_q;
  logic [1:0]  idx_d;
  logic        busy_q;
  logic        busy_d;

  logic [7:0]  out_data_s;
  logic        out_valid_s;
  logic        out_last_s;
  logic        in_ready_s;
  logic        out_acc_s;
  logic        crc_calc_s;
  logic        crc_clear_s;
  logic [31:0] crc_out_s;

`ifdef TX_FCS_INSERT_PAD_EN
  localparam int unsigned CNT_W = (MIN_LEN < 1) ? 1 : $clog2(MIN_LEN + 1);
  localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;

  // Byte count including the byte being accepted, saturating at MIN_LEN.
  assign cnt_inc_s = (cnt_q >= MIN_LEN_C) ? MIN_LEN_C : (cnt_q + CNT_W'(1));
`endif

  // Outputs are forced inactive while reset_n is low, independent of the clock.
  assign out_data  = reset_n ? out_data_s : 8'h00;
  assign out_valid = out_valid_s & reset_n;
  assign out_last  = out_last_s & reset_n;
  assign in_ready  = in_ready_s & reset_n;
  assign busy      = busy_q;

  assign out_acc_s   = out_valid & out_ready;
  assign crc_calc_s  = out_acc_s & (state_q != ST_FCS);
  assign crc_clear_s = out_acc_s & (state_q == ST_FCS) & (idx_q == 2'd3);

  tx_fcs_crc32 u_crc (
    .clk     (clk),
    .reset   (~reset_n),
    .data    (out_data),
    .calc    (crc_calc_s),
    .clear   (crc_clear_s),
    .crc_out (crc_out_s)
  );

  // Next-state and output decode. With out_ready low nothing advances, so
  // the presented byte stays stable until it is taken.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    out_data_s  = 8'h00;
    out_valid_s = 1'b0;
    out_last_s  = 1'b0;
    in_ready_s  = 1'b0;
`ifdef TX_FCS_INSERT_PAD_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_DATA: begin
        out_data_s  = in_data;
        out_valid_s = in_valid;
        in_ready_s  = out_ready;
        if (in_valid && out_ready) begin
          busy_d = 1'b1;
`ifdef TX_FCS_INSERT_PAD_EN
          cnt_d = cnt_inc_s;
          if (in_last) begin
            if (cnt_inc_s >= MIN_LEN_C) begin
              state_d = ST_FCS;
            end else begin
              state_d = ST_PAD;
            end
          end else begin
            state_d = ST_DATA;
          end
`else
          if (in_last) begin
            state_d = ST_FCS;
          end else begin
            state_d = ST_DATA;
          end
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef TX_FCS_INSERT_PAD_EN
      ST_PAD: begin
        out_data_s  = 8'h00;
        out_valid_s = 1'b1;
        if (out_ready) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == MIN_LEN_C) begin
            state_d = ST_FCS;
          end else begin
            state_d = ST_PAD;
          end
        end else begin
          state_d = ST_PAD;
        end
      end
`endif
      ST_FCS: begin
        out_valid_s = 1'b1;
        out_last_s  = (idx_q == 2'd3);
        case (idx_q)
          2'd0:    out_data_s = crc_out_s[31:24];
          2'd1:    out_data_s = crc_out_s[23:16];
          2'd2:    out_data_s = crc_out_s[15:8];
          2'd3:    out_data_s = crc_out_s[7:0];
          default: out_data_s = 8'h00;
        endcase
        if (out_ready) begin
          if (idx_q == 2'd3) begin
            state_d = ST_DATA;
            idx_d   = 2'd0;
            busy_d  = 1'b0;
`ifdef TX_FCS_INSERT_PAD_EN
            cnt_d   = '0;
`endif
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_DATA;
        idx_d   = 2'd0;
      end
    endcase
  end

  // State, FCS index and busy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_DATA;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

`ifdef TX_FCS_INSERT_PAD_EN
  // Frame byte counter used for padding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_tx_fcs_insert.sv
// ---------------------------------------------------------------------------
// tb_tx_fcs_insert
//
// Self-checking bench for tx_fcs_insert. A reference model builds the expected
// output stream of each frame directly from the frame bytes. It pads the frame
// when TX_FCS_INSERT_PAD_EN is defined, then appends a bitwise software CRC-32
// in wire order. A cycle loop drives the input and compares every accepted
// output beat, busy, and the stability of stalled beats against that stream.
// ---------------------------------------------------------------------------

module tb_tx_fcs_insert;

  localparam int MIN_LEN = 60;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int ready_pct = 100;

  logic [8:0] src_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] mbuf[$];

  always #5 clk = ~clk;

  tx_fcs_insert dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Software CRC-32 (reflected, init all ones, final complement) over mbuf.
  function automatic logic [31:0] crc_of_mbuf();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (mbuf[i]) begin
      for (int b = 0; b < 8; b++) begin
        if ((c[0] ^ mbuf[i][b]) == 1'b1) c = (c >> 1) ^ 32'hEDB8_8320;
        else c = c >> 1;
      end
    end
    return ~c;
  endfunction

  // Queue frame_q as input and its expected output stream.
  task automatic add_frame();
    logic [31:0] fcs;
    mbuf = {};
    foreach (frame_q[i]) begin
      src_q.push_back({(i == frame_q.size() - 1), frame_q[i]});
      mbuf.push_back(frame_q[i]);
    end
`ifdef TX_FCS_INSERT_PAD_EN
    while (mbuf.size() < MIN_LEN) mbuf.push_back(8'h00);
`endif
    fcs = crc_of_mbuf();
    foreach (mbuf[i]) exp_q.push_back({1'b0, mbuf[i]});
    exp_q.push_back({1'b0, fcs[7:0]});
    exp_q.push_back({1'b0, fcs[15:8]});
    exp_q.push_back({1'b0, fcs[23:16]});
    exp_q.push_back({1'b1, fcs[31:24]});
  endtask

  task automatic make_random_frame(input int len);
    frame_q = {};
    for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
  endtask

  task automatic make_ascii_frame();
    frame_q = {};
    for (int i = 0; i < 9; i++) frame_q.push_back(8'h31 + 8'(i));
  endtask

  // Drive src_q and score output beats until exp_q drains, stop_after beats
  // were seen, or max_cycles expire.
  task automatic run_stream(input int max_cycles, input int stop_after,
                            output int beats, output int cycles, output int rdy_low);
    logic       exp_busy;
    logic       hold;
    logic [8:0] held;
    beats = 0; cycles = 0; rdy_low = 0;
    exp_busy = 1'b0; hold = 1'b0; held = 9'h000;
    while (exp_q.size() > 0 && beats != stop_after && cycles < max_cycles) begin
      @(posedge clk); #1;
      if (src_q.size() > 0) begin
        in_valid = 1'b1;
        {in_last, in_data} = src_q[0];
      end else begin
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      cycles++;
      if (in_ready !== 1'b1) rdy_low++;
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy: got %b expected %b at beat %0d", busy, exp_busy, beats);
      end
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || {out_last, out_data} !== held) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h expected v=1 %h", out_valid, {out_last, out_data}, held);
        end
      end
      hold = out_valid && !out_ready;
      held = {out_last, out_data};
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if ({out_last, out_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL beat %0d: got last=%b data=%h expected last=%b data=%h",
                   beats, out_last, out_data, exp_q[0][8], exp_q[0][7:0]);
        end
        if (exp_q[0][8]) exp_busy = 1'b0;
        void'(exp_q.pop_front());
        beats++;
      end
      if (in_valid && in_ready === 1'b1) begin
        void'(src_q.pop_front());
        exp_busy = 1'b1;
      end
    end
    if (exp_q.size() > 0 && beats != stop_after) begin
      checks++; errors++;
      $display("FAIL stream_timeout: got %0d beats, %0d still expected", beats, exp_q.size());
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b1; out_ready = 1'b1;
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b r=%b d=%h b=%b expected all zero",
               out_valid, out_last, in_ready, out_data, busy);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    reset_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got v=%b b=%b r=%b expected v=0 b=0 r=1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_check_value();
    int beats, cycles, rl;
    src_q = {}; exp_q = {};
    mbuf = {};
    for (int i = 0; i < 9; i++) mbuf.push_back(8'h31 + 8'(i));
    checks++;
    if (crc_of_mbuf() !== 32'hCBF4_3926) begin
      errors++;
      $display("FAIL model_crc: got %h expected cbf43926", crc_of_mbuf());
    end
    make_ascii_frame();
    add_frame();
    ready_pct = 100;
    run_stream(500, -1, beats, cycles, rl);
    checks++;
`ifdef TX_FCS_INSERT_PAD_EN
    if (beats != 64) begin
      errors++; $display("FAIL ascii_beats: got %0d expected 64", beats);
    end
`else
    if (beats != 13) begin
      errors++; $display("FAIL ascii_beats: got %0d expected 13", beats);
    end
`endif
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL ascii_idle: got b=%b v=%b expected 0 0", busy, out_valid);
    end
  endtask

`ifdef TX_FCS_INSERT_PAD_EN
  task automatic test_pad();
    int beats, cycles, rl;
    int lens[3] = '{1, 60, 61};
    int exp_beats[3] = '{64, 64, 65};
    ready_pct = 100;
    for (int k = 0; k < 3; k++) begin
      src_q = {}; exp_q = {};
      make_random_frame(lens[k]);
      if (k == 0) frame_q[0] = 8'hAA;
      add_frame();
      run_stream(500, -1, beats, cycles, rl);
      checks++;
      if (beats != exp_beats[k]) begin
        errors++; $display("FAIL pad_beats len=%0d: got %0d expected %0d", lens[k], beats, exp_beats[k]);
      end
      if (k == 0) begin
        checks++;
        if (rl != 63) begin
          errors++; $display("FAIL pad_ready_low: got %0d expected 63", rl);
        end
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_back_to_back();
    int beats, cycles, rl, total;
    src_q = {}; exp_q = {};
    for (int f = 0; f < 3; f++) begin
      make_random_frame($urandom_range(1, 70));
      add_frame();
    end
    total = exp_q.size();
    ready_pct = 100;
    run_stream(2000, -1, beats, cycles, rl);
    checks++;
    if (beats != total || cycles != total) begin
      errors++; $display("FAIL b2b_no_idle: got beats=%0d cycles=%0d expected %0d", beats, cycles, total);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int beats, cycles, rl, total;
    src_q = {}; exp_q = {};
    for (int f = 0; f < 3; f++) begin
      make_random_frame($urandom_range(1, 70));
      add_frame();
    end
    total = exp_q.size();
    ready_pct = 50;
    run_stream(5000, -1, beats, cycles, rl);
    checks++;
    if (beats != total) begin
      errors++; $display("FAIL bp_beats: got %0d expected %0d", beats, total);
    end
    ready_pct = 100;
    @(posedge clk); #1;
    out_ready = 1'b1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_idle: got b=%b v=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_fcs();
    int beats, cycles, rl, stop;
    src_q = {}; exp_q = {};
    make_ascii_frame();
    add_frame();
    stop = exp_q.size() - 2;
    ready_pct = 100;
    run_stream(500, stop, beats, cycles, rl);
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b0 || out_data !== exp_q[0][7:0]) begin
      errors++;
      $display("FAIL fcs_idx2: got v=%b l=%b d=%h expected v=1 l=0 d=%h", out_valid, out_last, out_data, exp_q[0][7:0]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b l=%b d=%h b=%b expected 0 0 00 0", out_valid, out_last, out_data, busy);
    end
    in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL reset_gate: got r=%b v=%b d=%h expected 0 0 00", in_ready, out_valid, out_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00;
    reset_n = 1'b1;
    src_q = {}; exp_q = {};
    make_ascii_frame();
    add_frame();
    run_stream(500, -1, beats, cycles, rl);
    checks++;
`ifdef TX_FCS_INSERT_PAD_EN
    if (beats != 64) begin
      errors++; $display("FAIL post_reset_beats: got %0d expected 64", beats);
    end
`else
    if (beats != 13) begin
      errors++; $display("FAIL post_reset_beats: got %0d expected 13", beats);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_check_value();
`ifdef TX_FCS_INSERT_PAD_EN
    test_pad();
`endif
    test_back_to_back();
    test_backpressure();
    test_reset_mid_fcs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
